// File: rtl/janus_cube_pkg.sv
// Shared types and constants for the Janus cube tile sequencer.
package janus_cube_pkg;

    localparam int unsigned DIM_W  = 16;
    localparam int unsigned IDX_W  = 16;
    localparam int unsigned INST_W = 48;

    localparam int unsigned M_LSB = 0;
    localparam int unsigned K_LSB = 16;
    localparam int unsigned N_LSB = 32;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_RESET = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2
    } seq_state_e;

    // Entry indices are carried at full index width; the top truncates to ENTRY_W.
    typedef struct packed {
        logic [DIM_W-1:0] m;
        logic [DIM_W-1:0] n;
        logic [DIM_W-1:0] k;
        logic [IDX_W-1:0] l0a;
        logic [IDX_W-1:0] l0b;
        logic             first_k;
        logic             last_k;
    } uop_t;

    // Ceiling division by the tile size, one extra bit so 65535 cannot wrap.
    function automatic logic [DIM_W:0] tile_count(input logic [DIM_W-1:0] dim,
                                                  input int unsigned     tile_lg);
        logic [DIM_W:0] sum;
        sum = {1'b0, dim} + (DIM_W+1)'((1 << tile_lg) - 1);
        return sum >> tile_lg;
    endfunction

endpackage

// File: rtl/janus_cube_inst_fifo.sv
// Instruction queue for the tile sequencer: show-ahead synchronous FIFO with flush.
module janus_cube_inst_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             full_q;
    logic             empty_q;
    logic             push_ok;
    logic             pop_ok;

    // Full is judged on current occupancy, so a same-cycle pop never admits a push.
    assign push_ok = push && !full_q;
    assign pop_ok  = pop && !empty_q;

    always_comb begin
        count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (pop_ok)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wdata;
    end

    assign rdata = mem_q[rptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/janus_cube_tile_seq.sv
// Janus cube tile sequencer: queues MATMUL instructions and issues k/n/m-ordered tile uops.
// Optional build macro JANUS_CUBE_SEQ_STATS_EN adds accepted-uop and stall counters.
module janus_cube_tile_seq
    import janus_cube_pkg::*;
#(
    parameter int unsigned ARRAY_SIZE = 16,
    parameter int unsigned QDEPTH     = 4,
    parameter int unsigned ENTRY_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ctrl_reset,
    input  logic               ctrl_start,
    input  logic               inst_valid,
    input  logic [63:0]        inst_data,
    output logic               inst_ready,
    output logic               uop_valid,
    input  logic               uop_ready,
    output logic [15:0]        uop_m,
    output logic [15:0]        uop_n,
    output logic [15:0]        uop_k,
    output logic [ENTRY_W-1:0] uop_l0a,
    output logic [ENTRY_W-1:0] uop_l0b,
    output logic               uop_first_k,
    output logic               uop_last_k,
    output logic               done,
    output logic               busy,
    output logic               queue_full,
    output logic               queue_empty
`ifdef JANUS_CUBE_SEQ_STATS_EN
    ,
    output logic [31:0]        stat_uops,
    output logic [31:0]        stat_stall
`endif
);

    localparam int unsigned ARRAY_LG = $clog2(ARRAY_SIZE);

    logic              rst_all;
    logic [INST_W-1:0] head;
    logic              q_full;
    logic              q_empty;
    logic              pop_c;

    seq_state_e        state_q;
    logic              done_q;
    logic              valid_q;
    uop_t              uop_q;
    logic [DIM_W-1:0]  mt_q;
    logic [DIM_W-1:0]  nt_q;
    logic [DIM_W-1:0]  kt_q;

    logic [DIM_W:0]    ld_mt_c;
    logic [DIM_W:0]    ld_nt_c;
    logic [DIM_W:0]    ld_kt_c;
    logic              ld_zero_c;
    uop_t              uop_first_c;
    uop_t              uop_next_c;
    logic              last_c;
    logic              fire_c;
    logic              unused_c;

    assign rst_all = rst | ctrl_reset;
    assign fire_c  = valid_q && uop_ready;

    janus_cube_inst_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (INST_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (ctrl_reset),
        .push  (inst_valid),
        .wdata (inst_data[INST_W-1:0]),
        .pop   (pop_c),
        .rdata (head),
        .full  (q_full),
        .empty (q_empty)
    );

    // Decode the queue head into tile counts and the first uop of the instruction.
    always_comb begin
        ld_mt_c   = tile_count(head[M_LSB +: DIM_W], ARRAY_LG);
        ld_kt_c   = tile_count(head[K_LSB +: DIM_W], ARRAY_LG);
        ld_nt_c   = tile_count(head[N_LSB +: DIM_W], ARRAY_LG);
        ld_zero_c = (ld_mt_c == '0) || (ld_kt_c == '0) || (ld_nt_c == '0);
        pop_c     = (state_q == ST_LOAD) && !q_empty;
        uop_first_c         = '0;
        uop_first_c.first_k = 1'b1;
        uop_first_c.last_k  = (ld_kt_c == (DIM_W+1)'(1));
    end

    // Successor uop in k-innermost, then n, then m order.
    always_comb begin
        logic             k_wrap;
        logic             n_wrap;
        logic [DIM_W-1:0] nm;
        logic [DIM_W-1:0] nn;
        logic [DIM_W-1:0] nk;
        logic [31:0]      a_lin;
        logic [31:0]      b_lin;
        k_wrap = (uop_q.k == kt_q - DIM_W'(1));
        n_wrap = (uop_q.n == nt_q - DIM_W'(1));
        last_c = k_wrap && n_wrap && (uop_q.m == mt_q - DIM_W'(1));
        nk     = k_wrap ? '0 : uop_q.k + DIM_W'(1);
        nn     = k_wrap ? (n_wrap ? '0 : uop_q.n + DIM_W'(1)) : uop_q.n;
        nm     = (k_wrap && n_wrap) ? uop_q.m + DIM_W'(1) : uop_q.m;
        a_lin  = 32'(nm) * 32'(kt_q) + 32'(nk);
        b_lin  = 32'(nk) * 32'(nt_q) + 32'(nn);
        uop_next_c.m       = nm;
        uop_next_c.n       = nn;
        uop_next_c.k       = nk;
        uop_next_c.l0a     = IDX_W'(a_lin);
        uop_next_c.l0b     = IDX_W'(b_lin);
        uop_next_c.first_k = k_wrap;
        uop_next_c.last_k  = (nk == kt_q - DIM_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst_all) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            uop_q   <= '0;
            mt_q    <= '0;
            nt_q    <= '0;
            kt_q    <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ctrl_start) begin
                        done_q  <= 1'b0;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (q_empty) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (!ld_zero_c) begin
                        mt_q    <= DIM_W'(ld_mt_c);
                        nt_q    <= DIM_W'(ld_nt_c);
                        kt_q    <= DIM_W'(ld_kt_c);
                        uop_q   <= uop_first_c;
                        valid_q <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (fire_c) begin
                        if (last_c) begin
                            valid_q <= 1'b0;
                            state_q <= ST_LOAD;
                        end else begin
                            uop_q <= uop_next_c;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef JANUS_CUBE_SEQ_STATS_EN
    logic [31:0] stat_uops_q;
    logic [31:0] stat_stall_q;

    always_ff @(posedge clk) begin
        if (rst_all || ctrl_start) begin
            stat_uops_q  <= '0;
            stat_stall_q <= '0;
        end else begin
            if (fire_c)                 stat_uops_q  <= stat_uops_q + 32'd1;
            if (valid_q && !uop_ready)  stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign stat_uops  = stat_uops_q;
    assign stat_stall = stat_stall_q;
`else
    // Statistics counters are not built in this configuration.
`endif

    assign unused_c    = ^{inst_data[63:INST_W], uop_q.l0a, uop_q.l0b};

    assign inst_ready  = !q_full;
    assign queue_full  = q_full;
    assign queue_empty = q_empty;
    assign uop_valid   = valid_q;
    assign uop_m       = uop_q.m;
    assign uop_n       = uop_q.n;
    assign uop_k       = uop_q.k;
    assign uop_l0a     = uop_q.l0a[ENTRY_W-1:0];
    assign uop_l0b     = uop_q.l0b[ENTRY_W-1:0];
    assign uop_first_k = uop_q.first_k;
    assign uop_last_k  = uop_q.last_k;
    assign done        = done_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
